// File: rtl/result_serializer.sv
// Frame serializer: reads NWORDS result words and streams them as PART_W parts, MSB part first.
// Optional feature macro SERIALIZER_CHECKSUM_EN appends an XOR checksum part to every frame.
module result_serializer #(
    parameter int NWORDS = 9,
    parameter int WORD_W = 24,
    parameter int PART_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [4:0]        rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [PART_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done
);
    localparam logic [4:0] LAST_WORD = 5'(NWORDS - 1);
    localparam logic [1:0] LAST_PART = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
`ifdef SERIALIZER_CHECKSUM_EN
        CSUM  = 3'd4,
`endif
        FIN   = 3'd5
    } state_t;

    function automatic logic [PART_W-1:0] part_of(input logic [WORD_W-1:0] word,
                                                  input logic [1:0] idx);
        logic [PART_W-1:0] part;
        case (idx)
            2'd0:    part = word[3*PART_W-1 -: PART_W];
            2'd1:    part = word[2*PART_W-1 -: PART_W];
            2'd2:    part = word[PART_W-1:0];
            default: part = {PART_W{1'b0}};
        endcase
        return part;
    endfunction

    state_t              state_r, state_s;
    logic [4:0]          word_idx_r, word_idx_s;
    logic [1:0]          part_idx_r, part_idx_s;
    logic [WORD_W-1:0]   hold_r, hold_s;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [PART_W-1:0]   csum_r, csum_s;
`endif
    logic                rd_en_r, rd_en_s;
    logic [4:0]          rd_addr_r, rd_addr_s;
    logic [PART_W-1:0]   tx_data_r, tx_data_s;
    logic                tx_valid_r, tx_valid_s;
    logic                busy_r, busy_s;
    logic                frame_done_r, frame_done_s;
    logic                xfer_s;

    // Next-state, index/datapath updates and the output values they imply for the next cycle.
    always_comb begin
        state_s    = state_r;
        word_idx_s = word_idx_r;
        part_idx_s = part_idx_r;
        hold_s     = hold_r;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_s     = csum_r;
`endif
        xfer_s     = tx_valid_r && tx_ready;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = FETCH;
                    word_idx_s = 5'd0;
                    part_idx_s = 2'd0;
`ifdef SERIALIZER_CHECKSUM_EN
                    csum_s     = {PART_W{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: state_s = LATCH;
            LATCH: begin
                hold_s  = rd_data;
                state_s = SEND;
            end
            SEND: begin
                if (xfer_s) begin
`ifdef SERIALIZER_CHECKSUM_EN
                    csum_s = csum_r ^ tx_data_r;
`endif
                    if (part_idx_r != LAST_PART) begin
                        part_idx_s = part_idx_r + 2'd1;
                    end else if (word_idx_r != LAST_WORD) begin
                        word_idx_s = word_idx_r + 5'd1;
                        part_idx_s = 2'd0;
                        state_s    = FETCH;
                    end else begin
`ifdef SERIALIZER_CHECKSUM_EN
                        state_s = CSUM;
`else
                        state_s = FIN;
`endif
                    end
                end else begin
                    state_s = SEND;
                end
            end
`ifdef SERIALIZER_CHECKSUM_EN
            CSUM: begin
                if (xfer_s) begin
                    state_s = FIN;
                end else begin
                    state_s = CSUM;
                end
            end
`endif
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without extra latency.
        rd_en_s      = (state_s == FETCH);
        rd_addr_s    = rd_en_s ? word_idx_s : 5'd0;
        busy_s       = (state_s != IDLE);
        frame_done_s = (state_s == FIN);
        case (state_s)
            SEND: begin
                tx_valid_s = 1'b1;
                tx_data_s  = part_of(hold_s, part_idx_s);
            end
`ifdef SERIALIZER_CHECKSUM_EN
            CSUM: begin
                tx_valid_s = 1'b1;
                tx_data_s  = csum_s;
            end
`endif
            default: begin
                tx_valid_s = 1'b0;
                tx_data_s  = {PART_W{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            word_idx_r   <= 5'd0;
            part_idx_r   <= 2'd0;
            hold_r       <= {WORD_W{1'b0}};
`ifdef SERIALIZER_CHECKSUM_EN
            csum_r       <= {PART_W{1'b0}};
`endif
            rd_en_r      <= 1'b0;
            rd_addr_r    <= 5'd0;
            tx_data_r    <= {PART_W{1'b0}};
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_idx_r   <= word_idx_s;
            part_idx_r   <= part_idx_s;
            hold_r       <= hold_s;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_r       <= csum_s;
`endif
            rd_en_r      <= rd_en_s;
            rd_addr_r    <= rd_addr_s;
            tx_data_r    <= tx_data_s;
            tx_valid_r   <= tx_valid_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign rd_en      = rd_en_r;
    assign rd_addr    = rd_addr_r;
    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: memory model plus a queue-based expected part stream per frame.
module tb_result_serializer;
    localparam int NWORDS = 9;

    logic        clk = 1'b0;
    logic        rst, start, rd_en, tx_valid, tx_ready, busy, frame_done;
    logic [4:0]  rd_addr;
    logic [23:0] rd_data;
    logic [7:0]  tx_data;
    logic [23:0] mem [NWORDS];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;

    result_serializer #(.NWORDS(NWORDS), .WORD_W(24), .PART_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous result memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < NWORDS) rd_data <= mem[int'(rd_addr)];
        else rd_data <= 24'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame: every word split MSB part first, in address order, optional XOR trailer.
    task automatic build_exp();
        logic [7:0] x;
        exp_q.delete();
        x = 8'h00;
        for (int w = 0; w < NWORDS; w++) begin
            for (int p = 0; p < 3; p++) begin
                logic [7:0] b;
                b = 8'((mem[w] >> (8 * (2 - p))) & 24'hFF);
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef SERIALIZER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // mode 0: ready always 1, 1: ready toggles, 2: ready random. second_at: cycle of an extra start.
    task automatic run_frame(input string tag, input int mode, input int second_at);
        int         n, dones, done_cycle, stray;
        logic       prev_hold, finished;
        logic [7:0] prev_data;
        build_exp();
        n = 0; dones = 0; done_cycle = -1; stray = 0;
        prev_hold = 1'b0; prev_data = 8'h00; finished = 1'b0;
        start = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        for (int k = 1; k < 400 && !finished; k++) begin
            start = (k == second_at);
            if (prev_hold) begin
                check({tag, " stall_valid"}, 32'(tx_valid), 32'd1);
                check({tag, " stall_data"}, 32'(tx_data), 32'(prev_data));
            end
            if (!rd_en) check({tag, " rd_addr_idle"}, 32'(rd_addr), 32'd0);
            else check({tag, " rd_addr_range"}, 32'(int'(rd_addr) < NWORDS), 32'd1);
            if (dones == 0) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
            end else begin
                check({tag, " busy_after"}, 32'(busy), 32'd0);
                check({tag, " done_len"}, 32'(frame_done), 32'd0);
                finished = 1'b1;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = k[0];
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid && tx_ready) begin
                if (n < exp_q.size()) check({tag, " part"}, 32'(tx_data), 32'(exp_q[n]));
                else check({tag, " extra_part"}, 32'(n), 32'(exp_q.size()));
                n++;
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (frame_done) begin
                dones++;
                done_cycle = k;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tx_ready = 1'b0;
        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " parts"}, 32'(n), 32'(exp_q.size()));
        check({tag, " dones"}, 32'(dones), 32'd1);
        if (mode == 0) check({tag, " done_cycle"}, 32'(done_cycle), 32'(5 * NWORDS + exp_q.size() - 3 * NWORDS + 1));
        for (int k = 0; k < 6; k++) begin
            if (rd_en || busy) stray++;
            @(negedge clk);
        end
        check({tag, " no_queued_start"}, 32'(stray), 32'd0);
    endtask

    initial begin
        int stray;
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
        for (int w = 0; w < NWORDS; w++) mem[w] = 24'h0;
        repeat (3) @(negedge clk);
        check("rst rd_en", 32'(rd_en), 32'd0);
        check("rst rd_addr", 32'(rd_addr), 32'd0);
        check("rst tx_valid", 32'(tx_valid), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int w = 0; w < NWORDS; w++)
            mem[w] = {8'(3 * w + 1), 8'(3 * w + 2), 8'(3 * w + 3)};
        run_frame("basic", 0, -1);
        run_frame("toggle", 1, -1);
        run_frame("restart", 0, 10);

        // Abort mid-frame while word 4 part 1 is on the bus.
        start = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && !(tx_valid && tx_data == 8'h0E); k++) @(negedge clk);
        check("abort reach", 32'(tx_valid && tx_data == 8'h0E), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b0;
        check("abort tx_valid", 32'(tx_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort frame_done", 32'(frame_done), 32'd0);
        stray = 0;
        for (int k = 0; k < 60; k++) begin
            if (frame_done || rd_en || busy) stray++;
            @(negedge clk);
        end
        check("abort quiet", 32'(stray), 32'd0);
        run_frame("after_abort", 0, -1);

        // start and rst on the same edge: reset wins.
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            if (rd_en || busy) stray++;
            @(negedge clk);
        end
        check("rst_start idle", 32'(stray), 32'd0);

        for (int w = 0; w < NWORDS; w++) mem[w] = 24'($urandom);
        run_frame("rand_stall", 2, -1);
        for (int w = 0; w < NWORDS; w++) mem[w] = 24'($urandom);
        run_frame("rand_flow", 0, -1);

        for (int w = 0; w < NWORDS; w++) mem[w] = 24'hFFFFFF;
        run_frame("all_ff", 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
